// File: rtl/ad7124_spi_responder_pkg.sv
// rtl/ad7124_spi_responder_pkg.sv - shared AD7124 responder definitions
// Purpose: register addresses, reset values, bit positions, FSM encoding and
//          the register width lookup used by the responder.
// Ports:   none (package).
package ad7124_spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMM = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_e;

  localparam logic [5:0] ADDR_STATUS   = 6'h00;
  localparam logic [5:0] ADDR_ADC_CTRL = 6'h01;
  localparam logic [5:0] ADDR_DATA     = 6'h02;
  localparam logic [5:0] ADDR_IO_CON1  = 6'h03;
  localparam logic [5:0] ADDR_IO_CON2  = 6'h04;
  localparam logic [5:0] ADDR_ID       = 6'h05;
  localparam logic [5:0] ADDR_CH0      = 6'h09;
  localparam logic [5:0] ADDR_CFG0     = 6'h19;

  localparam logic [7:0]  STATUS_RST   = 8'h80;
  localparam logic [15:0] ADC_CTRL_RST = 16'h0000;
  localparam logic [23:0] DATA_RST     = 24'h000000;
  localparam logic [23:0] IO_CON1_RST  = 24'h000000;
  localparam logic [15:0] IO_CON2_RST  = 16'h0000;
  localparam logic [15:0] CH0_RST      = 16'h8001;
  localparam logic [15:0] CHN_RST      = 16'h0001;
  localparam logic [15:0] CFG_RST      = 16'h0860;

  localparam int STATUS_RDY_BIT       = 7;
  localparam int ADC_CTRL_DATA_STATUS = 10;

  // Number of consecutive SDI ones that trigger the interface soft reset.
  localparam logic [6:0] SOFT_RST_ONES = 7'd64;

  // Transfer width in bits of a register access; unknown addresses move one byte.
  function automatic logic [5:0] reg_width(input logic [5:0] a,
                                           input logic [5:0] ch_last,
                                           input logic [5:0] cfg_last);
    logic [5:0] w;
    w = 6'd8;
    if (a >= ADDR_CH0 && a <= ch_last) begin
      w = 6'd16;
    end else if (a >= ADDR_CFG0 && a <= cfg_last) begin
      w = 6'd16;
    end else begin
      case (a)
        ADDR_ADC_CTRL: w = 6'd16;
        ADDR_DATA:     w = 6'd24;
        ADDR_IO_CON1:  w = 6'd24;
        ADDR_IO_CON2:  w = 6'd16;
        default:       w = 6'd8;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/ad7124_spi_responder_if.sv
// rtl/ad7124_spi_responder_if.sv - SPI pin bundle for the AD7124 responder
// Purpose: groups the four-wire SPI pins plus the DOUT tristate enable.
// Signals: spi_sclk, spi_csn, spi_sdi (master -> responder),
//          spi_sdo_o, spi_sdo_t (responder -> master, sdo_t=1 means high-Z).
interface ad7124_spi_responder_if;
  logic spi_sclk;
  logic spi_csn;
  logic spi_sdi;
  logic spi_sdo_o;
  logic spi_sdo_t;

  modport master (
    output spi_sclk,
    output spi_csn,
    output spi_sdi,
    input  spi_sdo_o,
    input  spi_sdo_t
  );

  modport slave (
    input  spi_sclk,
    input  spi_csn,
    input  spi_sdi,
    output spi_sdo_o,
    output spi_sdo_t
  );
endinterface

// File: rtl/ad7124_spi_responder_sync.sv
// rtl/ad7124_spi_responder_sync.sv - SPI pin synchroniser and edge detector
// Purpose: 2-FF synchronisers for sclk/csn/sdi (preset to 1) and single-cycle
//          edge pulses derived from the synchronised sclk and csn.
// Ports:   clk_i, rst_ni          clock, async active-low reset
//          sclk_i, csn_i, sdi_i   raw SPI pins
//          csn_o, sdi_o           synchronised levels
//          sclk_rise_o/fall_o     detected SCLK edges
//          csn_fall_o/rise_o      detected chip-select edges
module ad7124_spi_responder_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic sdi_i,
  output logic csn_o,
  output logic sdi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic csn_fall_o,
  output logic csn_rise_o
);

  // [0],[1] are the synchroniser stages; [2] holds the previous synced value.
  logic [2:0] sclk_q;
  logic [2:0] csn_q;
  logic [1:0] sdi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= 3'b111;
      csn_q  <= 3'b111;
      sdi_q  <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      csn_q  <= {csn_q[1:0], csn_i};
      sdi_q  <= {sdi_q[0], sdi_i};
    end
  end

  assign csn_o       = csn_q[1];
  assign sdi_o       = sdi_q[1];
  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
  assign csn_fall_o  = ~csn_q[1] & csn_q[2];
  assign csn_rise_o  = csn_q[1] & ~csn_q[2];

endmodule

// File: rtl/ad7124_spi_responder.sv
// rtl/ad7124_spi_responder.sv - AD7124 ADC SPI responder model
// Purpose: behaves as one AD7124 on a mode-3 SPI bus: decodes comms bytes,
//          serves register reads/writes, presents fabric-fed conversion
//          results and drives DOUT/RDY.
// Ports:   aclk, aresetn                  clock (>= 8x SCLK), async active-low reset
//          spi (slave modport)            sclk/csn/sdi in, sdo_o/sdo_t out
//          smp_valid, smp_data, smp_ch    new conversion result pulse
//          rdy_n                          STATUS[7] mirror
//          reg_wr, reg_wr_addr, reg_wr_data  committed write report
module ad7124_spi_responder
  import ad7124_spi_responder_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'h14,
  parameter int         NUM_CH   = 16,
  parameter int         NUM_CFG  = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  ad7124_spi_responder_if.slave         spi,
  input  logic                          smp_valid,
  input  logic [23:0]                   smp_data,
  input  logic [3:0]                    smp_ch,
  output logic                          rdy_n,
  output logic                          reg_wr,
  output logic [5:0]                    reg_wr_addr,
  output logic [23:0]                   reg_wr_data
);

  localparam logic [5:0] CH_LAST  = 6'(ADDR_CH0 + NUM_CH - 1);
  localparam logic [5:0] CFG_LAST = 6'(ADDR_CFG0 + NUM_CFG - 1);

  logic csn_s, sdi_s, sclk_rise, sclk_fall, csn_fall, csn_rise;

  ad7124_spi_responder_sync u_sync (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .sclk_i      (spi.spi_sclk),
    .csn_i       (spi.spi_csn),
    .sdi_i       (spi.spi_sdi),
    .csn_o       (csn_s),
    .sdi_o       (sdi_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .csn_fall_o  (csn_fall),
    .csn_rise_o  (csn_rise)
  );

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [5:0]  width_q;
  logic [5:0]  addr_q;
  logic [22:0] sin_q;
  logic [31:0] sout_q;
  logic [6:0]  ones_q;
  logic        sdo_q, sdo_t_q;
  logic        reg_wr_q;
  logic [5:0]  reg_wr_addr_q;
  logic [23:0] reg_wr_data_q;

  logic [7:0]  status_q;
  logic [15:0] adc_ctrl_q;
  logic [23:0] data_q;
  logic [23:0] io_con1_q;
  logic [15:0] io_con2_q;
  logic [15:0] ch_q  [NUM_CH];
  logic [15:0] cfg_q [NUM_CFG];

  // Comms-byte decode, evaluated with the current SDI bit as the byte's LSB.
  logic [7:0]  comm_byte_d;
  logic [5:0]  dec_addr_d;
  logic        dec_rd_d;
  logic [5:0]  dec_width_d;
  logic        dec_is_ch, dec_is_cfg;
  logic [3:0]  dec_ch_off;
  logic [2:0]  dec_cfg_off;
  logic [31:0] rd_val_d;

  logic [23:0] wr_word_d;
  logic        wr_is_ch, wr_is_cfg;
  logic [3:0]  wr_ch_off;
  logic [2:0]  wr_cfg_off;
  logic        last_bit_d;
  logic        soft_rst_d;

  assign comm_byte_d = {sin_q[6:0], sdi_s};
  assign dec_addr_d  = comm_byte_d[5:0];
  assign dec_rd_d    = comm_byte_d[6];
  assign dec_is_ch   = (dec_addr_d >= ADDR_CH0)  && (dec_addr_d <= CH_LAST);
  assign dec_is_cfg  = (dec_addr_d >= ADDR_CFG0) && (dec_addr_d <= CFG_LAST);
  assign dec_ch_off  = 4'(dec_addr_d - ADDR_CH0);
  assign dec_cfg_off = 3'(dec_addr_d - ADDR_CFG0);

  // DATA reads grow to 32 bits when the STATUS byte is appended.
  assign dec_width_d = (dec_rd_d && dec_addr_d == ADDR_DATA && adc_ctrl_q[ADC_CTRL_DATA_STATUS])
                       ? 6'd32 : reg_width(dec_addr_d, CH_LAST, CFG_LAST);

  always_comb begin
    rd_val_d = '0;
    if (dec_is_ch) begin
      rd_val_d = {16'h0, ch_q[dec_ch_off]};
    end else if (dec_is_cfg) begin
      rd_val_d = {16'h0, cfg_q[dec_cfg_off]};
    end else begin
      case (dec_addr_d)
        ADDR_STATUS:   rd_val_d = {24'h0, status_q};
        ADDR_ADC_CTRL: rd_val_d = {16'h0, adc_ctrl_q};
        ADDR_DATA:     rd_val_d = adc_ctrl_q[ADC_CTRL_DATA_STATUS] ? {data_q, status_q}
                                                                   : {8'h0, data_q};
        ADDR_IO_CON1:  rd_val_d = {8'h0, io_con1_q};
        ADDR_IO_CON2:  rd_val_d = {16'h0, io_con2_q};
        ADDR_ID:       rd_val_d = {24'h0, ID_VALUE};
        default:       rd_val_d = '0;
      endcase
    end
  end

  // The shift-in register is cleared at decode, so the word is right-aligned.
  assign wr_word_d  = {sin_q, sdi_s};
  assign wr_is_ch   = (addr_q >= ADDR_CH0)  && (addr_q <= CH_LAST);
  assign wr_is_cfg  = (addr_q >= ADDR_CFG0) && (addr_q <= CFG_LAST);
  assign wr_ch_off  = 4'(addr_q - ADDR_CH0);
  assign wr_cfg_off = 3'(addr_q - ADDR_CFG0);
  assign last_bit_d = ({1'b0, bit_cnt_q} == (width_q - 6'd1));
  assign soft_rst_d = sclk_rise && sdi_s && (ones_q == SOFT_RST_ONES - 7'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      width_q       <= 6'd8;
      addr_q        <= '0;
      sin_q         <= '0;
      sout_q        <= '0;
      ones_q        <= '0;
      sdo_q         <= 1'b1;
      sdo_t_q       <= 1'b1;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      status_q      <= STATUS_RST;
      adc_ctrl_q    <= ADC_CTRL_RST;
      data_q        <= DATA_RST;
      io_con1_q     <= IO_CON1_RST;
      io_con2_q     <= IO_CON2_RST;
      for (int i = 0; i < NUM_CH; i++)  ch_q[i]  <= (i == 0) ? CH0_RST : CHN_RST;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST;
    end else begin
      reg_wr_q <= 1'b0;
      if (csn_s) begin
        // Deselected: release DOUT and abandon any partial transfer.
        sdo_q   <= 1'b1;
        sdo_t_q <= 1'b1;
        ones_q  <= '0;
        if (csn_rise) begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
        end
      end else begin
        sdo_t_q <= 1'b0;
        if (csn_fall) begin
          state_q   <= ST_COMM;
          bit_cnt_q <= '0;
          ones_q    <= '0;
          sdo_q     <= status_q[STATUS_RDY_BIT];
        end else begin
          if (sclk_fall) begin
            if (state_q == ST_RD) begin
              sdo_q  <= sout_q[31];
              sout_q <= {sout_q[30:0], 1'b0};
            end else begin
              sdo_q <= status_q[STATUS_RDY_BIT];
            end
          end
          if (sclk_rise) begin
            ones_q <= sdi_s ? ones_q + 7'd1 : 7'd0;
            if (soft_rst_d) begin
              state_q    <= ST_COMM;
              bit_cnt_q  <= '0;
              sin_q      <= '0;
              ones_q     <= '0;
              status_q   <= STATUS_RST;
              adc_ctrl_q <= ADC_CTRL_RST;
              data_q     <= DATA_RST;
              io_con1_q  <= IO_CON1_RST;
              io_con2_q  <= IO_CON2_RST;
              for (int i = 0; i < NUM_CH; i++)  ch_q[i]  <= (i == 0) ? CH0_RST : CHN_RST;
              for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST;
            end else begin
              case (state_q)
                ST_COMM: begin
                  sin_q <= {sin_q[21:0], sdi_s};
                  if (bit_cnt_q == 5'd7) begin
                    bit_cnt_q <= '0;
                    // A set bit 7 (WEN high) means the byte is not a command.
                    if (!comm_byte_d[7]) begin
                      addr_q  <= dec_addr_d;
                      width_q <= dec_width_d;
                      sin_q   <= '0;
                      if (dec_rd_d) begin
                        state_q <= ST_RD;
                        sout_q  <= rd_val_d << (6'd32 - dec_width_d);
                      end else begin
                        state_q <= ST_WR;
                      end
                    end
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
                end
                ST_WR: begin
                  sin_q <= {sin_q[21:0], sdi_s};
                  if (last_bit_d) begin
                    state_q       <= ST_COMM;
                    bit_cnt_q     <= '0;
                    reg_wr_q      <= 1'b1;
                    reg_wr_addr_q <= addr_q;
                    reg_wr_data_q <= wr_word_d;
                    if (wr_is_ch) begin
                      ch_q[wr_ch_off] <= wr_word_d[15:0];
                    end else if (wr_is_cfg) begin
                      cfg_q[wr_cfg_off] <= wr_word_d[15:0];
                    end else begin
                      case (addr_q)
                        ADDR_ADC_CTRL: adc_ctrl_q <= wr_word_d[15:0];
                        ADDR_IO_CON1:  io_con1_q  <= wr_word_d;
                        ADDR_IO_CON2:  io_con2_q  <= wr_word_d[15:0];
                        default: ;
                      endcase
                    end
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
                end
                ST_RD: begin
                  if (last_bit_d) begin
                    state_q   <= ST_COMM;
                    bit_cnt_q <= '0;
                    if (addr_q == ADDR_DATA) status_q[STATUS_RDY_BIT] <= 1'b1;
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end
      // Placed last so a fresh sample overrides a coincident DATA-read completion.
      if (smp_valid) begin
        data_q                   <= smp_data;
        status_q[3:0]            <= smp_ch;
        status_q[STATUS_RDY_BIT] <= 1'b0;
      end
    end
  end

  assign spi.spi_sdo_o = sdo_q;
  assign spi.spi_sdo_t = sdo_t_q;
  assign rdy_n         = status_q[STATUS_RDY_BIT];
  assign reg_wr        = reg_wr_q;
  assign reg_wr_addr   = reg_wr_addr_q;
  assign reg_wr_data   = reg_wr_data_q;

endmodule

// File: tb/tb_ad7124_spi_responder.sv
// tb/tb_ad7124_spi_responder.sv - directed bench for ad7124_spi_responder
module tb_ad7124_spi_responder;

  logic        aclk;
  logic        aresetn;
  logic        smp_valid;
  logic [23:0] smp_data;
  logic [3:0]  smp_ch;
  logic        rdy_n;
  logic        reg_wr;
  logic [5:0]  reg_wr_addr;
  logic [23:0] reg_wr_data;

  ad7124_spi_responder_if spi_if ();

  ad7124_spi_responder #(
    .ID_VALUE (8'h14),
    .NUM_CH   (16),
    .NUM_CFG  (8)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .spi         (spi_if),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ch      (smp_ch),
    .rdy_n       (rdy_n),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;

  always @(negedge aclk) begin
    if (reg_wr) wr_cnt++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half_bit();
    repeat (8) @(negedge aclk);
  endtask

  task automatic cs_assert();
    @(negedge aclk);
    spi_if.spi_csn = 1'b0;
    half_bit();
  endtask

  task automatic cs_release();
    half_bit();
    spi_if.spi_csn = 1'b1;
    half_bit();
  endtask

  // Mode 3: drive SDI on the falling edge, sample SDO just before the rising edge.
  task automatic spi_xfer(input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
    miso = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_sdi  = mosi[i];
      half_bit();
      miso = {miso[30:0], spi_if.spi_sdo_o};
      spi_if.spi_sclk = 1'b1;
      half_bit();
    end
  endtask

  task automatic sample_pulse(input logic [23:0] d, input logic [3:0] ch);
    @(negedge aclk);
    smp_valid = 1'b1;
    smp_data  = d;
    smp_ch    = ch;
    @(negedge aclk);
    smp_valid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic reg_read(input logic [7:0] comm, input int nbits, output logic [31:0] val);
    logic [31:0] dummy;
    cs_assert();
    spi_xfer({24'h0, comm}, 8, dummy);
    spi_xfer(32'h0, nbits, val);
    cs_release();
  endtask

  task automatic reg_write(input logic [7:0] comm, input logic [31:0] val, input int nbits);
    logic [31:0] dummy;
    cs_assert();
    spi_xfer({24'h0, comm}, 8, dummy);
    spi_xfer(val, nbits, dummy);
    cs_release();
  endtask

  initial begin
    repeat (40000) @(posedge aclk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv, rv2, dummy;
    int wr_before;

    aresetn        = 1'b0;
    spi_if.spi_sclk = 1'b1;
    spi_if.spi_csn  = 1'b1;
    spi_if.spi_sdi  = 1'b0;
    smp_valid      = 1'b0;
    smp_data       = '0;
    smp_ch         = '0;
    repeat (4) @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);

    expect_eq("rst_sdo_t", {31'h0, spi_if.spi_sdo_t}, 32'h1);
    expect_eq("rst_sdo_o", {31'h0, spi_if.spi_sdo_o}, 32'h1);
    expect_eq("rst_rdy_n", {31'h0, rdy_n}, 32'h1);
    expect_eq("rst_reg_wr", {31'h0, reg_wr}, 32'h0);
    expect_eq("rst_wr_addr", {26'h0, reg_wr_addr}, 32'h0);
    expect_eq("rst_wr_data", {8'h0, reg_wr_data}, 32'h0);

    // ID read
    reg_read(8'h45, 8, rv);
    expect_eq("id_read", rv, 32'h14);
    expect_eq("id_no_wr", wr_cnt, 0);

    // DATA_STATUS enable, then sample and 32-bit DATA read
    reg_write(8'h01, 32'h0400, 16);
    expect_eq("adcctl_wr_cnt", wr_cnt, 1);
    expect_eq("adcctl_wr_addr", {26'h0, reg_wr_addr}, 32'h01);
    expect_eq("adcctl_wr_data", {8'h0, reg_wr_data}, 32'h000400);
    sample_pulse(24'hABCDEF, 4'd3);
    expect_eq("smp_rdy_low", {31'h0, rdy_n}, 32'h0);
    cs_assert();
    expect_eq("sdo_is_rdy", {31'h0, spi_if.spi_sdo_o}, 32'h0);
    spi_xfer(32'h42, 8, dummy);
    spi_xfer(32'h0, 31, rv);
    expect_eq("rdy_before_last", {31'h0, rdy_n}, 32'h0);
    spi_xfer(32'h0, 1, rv2);
    cs_release();
    expect_eq("data_status_read", {rv[30:0], rv2[0]}, 32'hABCDEF03);
    expect_eq("rdy_after_read", {31'h0, rdy_n}, 32'h1);

    // CHANNEL_1 write and readback
    reg_write(8'h0A, 32'h1234, 16);
    expect_eq("ch1_wr_cnt", wr_cnt, 2);
    expect_eq("ch1_wr_addr", {26'h0, reg_wr_addr}, 32'h0A);
    expect_eq("ch1_wr_data", {8'h0, reg_wr_data}, 32'h001234);
    reg_read(8'h4A, 16, rv);
    expect_eq("ch1_readback", rv, 32'h1234);

    // Aborted write after 10 bits
    cs_assert();
    spi_xfer(32'h0A, 8, dummy);
    spi_xfer(32'h3, 2, dummy);
    cs_release();
    expect_eq("abort_no_wr", wr_cnt, 2);
    reg_read(8'h4A, 16, rv);
    expect_eq("abort_ch1_kept", rv, 32'h1234);

    // Soft reset via 64 ones, then reads in the same frame
    wr_before = wr_cnt;
    cs_assert();
    spi_xfer(32'hFFFFFFFF, 32, dummy);
    spi_xfer(32'hFFFFFFFF, 32, dummy);
    spi_xfer(32'h49, 8, dummy);
    spi_xfer(32'h0, 16, rv);
    expect_eq("srst_ch0", rv, 32'h8001);
    spi_xfer(32'h40, 8, dummy);
    spi_xfer(32'h0, 8, rv);
    expect_eq("srst_status", rv, 32'h80);
    spi_xfer(32'h4A, 8, dummy);
    spi_xfer(32'h0, 16, rv);
    expect_eq("srst_ch1", rv, 32'h0001);
    spi_xfer(32'h41, 8, dummy);
    spi_xfer(32'h0, 16, rv);
    expect_eq("srst_adcctl", rv, 32'h0000);
    cs_release();
    expect_eq("srst_no_wr", wr_cnt, wr_before);

    // 24-bit DATA read with DATA_STATUS cleared
    sample_pulse(24'h123456, 4'd5);
    reg_read(8'h42, 24, rv);
    expect_eq("data24_read", rv, 32'h123456);
    reg_read(8'h40, 8, rv);
    expect_eq("status_after_data", rv, 32'h85);

    // WEN=1 byte ignored, following ID read works; release tristates
    cs_assert();
    spi_xfer(32'h85, 8, dummy);
    spi_xfer(32'h45, 8, dummy);
    spi_xfer(32'h0, 8, rv);
    expect_eq("wen_sdo_t_low", {31'h0, spi_if.spi_sdo_t}, 32'h0);
    cs_release();
    expect_eq("wen_id_read", rv, 32'h14);
    expect_eq("csn_high_sdo_t", {31'h0, spi_if.spi_sdo_t}, 32'h1);
    expect_eq("csn_high_sdo_o", {31'h0, spi_if.spi_sdo_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
